// File: rtl/fir_pkg.sv
// Shared FIR definitions: controller state encoding and derived-width helpers
// used by the FIR core and its downstream accumulator/resize stage.
package fir_pkg;

    typedef enum logic [1:0] {
        SM_IDLE,
        SM_SUM,
        SM_ROUND,
        SM_OUT
    } state_t;

    // Width of one per-stage partial accumulator.
    function automatic int calc_p(input int stage_depth_log2, input int data_width,
                                  input int tap_width);
        return stage_depth_log2 + data_width + tap_width;
    endfunction

    // Width of the sum over all lanes; one extra bit per doubling of the lane count.
    function automatic int calc_s(input int p, input int num_stages_log2);
        return p + num_stages_log2;
    endfunction

    function automatic int calc_sh_w(input int s);
        return $clog2(s);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Arithmetic right shift with round-half-up, then saturation of a wide signed
// sum to a D-bit signed result. Purely combinational.
module fir_round_sat #(
    parameter int S = 36,
    parameter int D = 16,
    localparam int SH_W = $clog2(S)
) (
    input  logic signed [S-1:0]    sum,
    input  logic        [SH_W-1:0] shift,
    output logic        [D-1:0]    dout,
    output logic                   sat
);

    localparam logic signed [S:0] MAX_POS = {{(S-D+2){1'b0}}, {(D-1){1'b1}}};
    localparam logic signed [S:0] MIN_NEG = {{(S-D+2){1'b1}}, {(D-1){1'b0}}};
    localparam logic signed [S:0] ONE     = {{S{1'b0}}, 1'b1};

    logic signed [S:0] sum_ext;
    logic signed [S:0] bias;
    logic signed [S:0] rounded;

    // One extra bit of headroom so adding the half-LSB bias can never wrap.
    always_comb begin
        sum_ext = {sum[S-1], sum};
        bias    = '0;
        if (shift != '0) begin
            bias = ONE << (shift - SH_W'(1));
        end
        rounded = (sum_ext + bias) >>> shift;

        dout = rounded[D-1:0];
        sat  = 1'b0;
        if (rounded > MAX_POS) begin
            dout = MAX_POS[D-1:0];
            sat  = 1'b1;
        end else if (rounded < MIN_NEG) begin
            dout = MIN_NEG[D-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_accum_resize.sv
// Sequentially sums the N signed per-stage partials of a FIR pass, then rounds,
// saturates and presents the result on a ready/valid output stream.
module fir_accum_resize
    import fir_pkg::*;
#(
    parameter int  G_NUM_STAGES_LOG2  = 2,
    parameter int  G_STAGE_DEPTH_LOG2 = 2,
    parameter int  G_DATA_WIDTH       = 16,
    parameter int  G_TAP_WIDTH        = 16,
    localparam int N    = 2 ** G_NUM_STAGES_LOG2,
    localparam int P    = calc_p(G_STAGE_DEPTH_LOG2, G_DATA_WIDTH, G_TAP_WIDTH),
    localparam int S    = calc_s(P, G_NUM_STAGES_LOG2),
    localparam int SH_W = calc_sh_w(S)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [SH_W-1:0]         shift,
    input  logic [N*P-1:0]          acc_din,
    input  logic                    acc_din_valid,
    output logic                    acc_din_ready,
    output logic [G_DATA_WIDTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_sat
);

    localparam int CNT_W = (G_NUM_STAGES_LOG2 > 0) ? G_NUM_STAGES_LOG2 : 1;
    localparam logic [SH_W-1:0] SHIFT_MAX = SH_W'(S - 1);

    state_t                  state_reg, state_next;
    logic signed [S-1:0]     sum_reg, sum_next;
    logic [CNT_W-1:0]        lane_cnt_reg, lane_cnt_next;
    logic [SH_W-1:0]         shift_reg, shift_next;
    logic                    acc_din_ready_reg, acc_din_ready_next;
    logic [G_DATA_WIDTH-1:0] dout_reg, dout_next;
    logic                    dout_valid_reg, dout_valid_next;
    logic                    dout_sat_reg, dout_sat_next;
    logic                    load;

    logic signed [P-1:0]     lane_in  [N];
    logic signed [P-1:0]     lane_reg [N];
    logic signed [S-1:0]     lane_ext;
    logic [G_DATA_WIDTH-1:0] rs_dout;
    logic                    rs_sat;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign lane_in[gi] = acc_din[gi*P +: P];
        end
    endgenerate

    // Lane contents are only meaningful after a capture, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!reset && enable && load) begin
            lane_reg <= lane_in;
        end
    end

    fir_round_sat #(
        .S (S),
        .D (G_DATA_WIDTH)
    ) u_round_sat (
        .sum   (sum_reg),
        .shift (shift_reg),
        .dout  (rs_dout),
        .sat   (rs_sat)
    );

    always_comb begin
        state_next         = state_reg;
        sum_next           = sum_reg;
        lane_cnt_next      = lane_cnt_reg;
        shift_next         = shift_reg;
        acc_din_ready_next = acc_din_ready_reg;
        dout_next          = dout_reg;
        dout_valid_next    = dout_valid_reg;
        dout_sat_next      = dout_sat_reg;
        load               = 1'b0;
        lane_ext           = S'(lane_reg[lane_cnt_reg]);

        case (state_reg)
            SM_IDLE: begin
                acc_din_ready_next = 1'b1;
                if (acc_din_valid && acc_din_ready_reg) begin
                    load               = 1'b1;
                    shift_next         = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
                    sum_next           = '0;
                    lane_cnt_next      = '0;
                    acc_din_ready_next = 1'b0;
                    state_next         = SM_SUM;
                end
            end
            SM_SUM: begin
                // S = P + log2(N) bits, so this running sum cannot overflow.
                sum_next      = sum_reg + lane_ext;
                lane_cnt_next = lane_cnt_reg + CNT_W'(1);
                if (lane_cnt_reg == CNT_W'(N - 1)) begin
                    state_next = SM_ROUND;
                end
            end
            SM_ROUND: begin
                dout_next       = rs_dout;
                dout_sat_next   = rs_sat;
                dout_valid_next = 1'b1;
                state_next      = SM_OUT;
            end
            SM_OUT: begin
                if (dout_ready) begin
                    dout_valid_next    = 1'b0;
                    acc_din_ready_next = 1'b1;
                    state_next         = SM_IDLE;
                end
            end
            default: begin
                state_next = SM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state_reg         <= SM_IDLE;
            sum_reg           <= '0;
            lane_cnt_reg      <= '0;
            shift_reg         <= '0;
            acc_din_ready_reg <= 1'b0;
            dout_reg          <= '0;
            dout_valid_reg    <= 1'b0;
            dout_sat_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            sum_reg           <= sum_next;
            lane_cnt_reg      <= lane_cnt_next;
            shift_reg         <= shift_next;
            acc_din_ready_reg <= acc_din_ready_next;
            dout_reg          <= dout_next;
            dout_valid_reg    <= dout_valid_next;
            dout_sat_reg      <= dout_sat_next;
        end
    end

    assign acc_din_ready = acc_din_ready_reg;
    assign dout          = dout_reg;
    assign dout_valid    = dout_valid_reg;
    assign dout_sat      = dout_sat_reg;

endmodule

// File: tb/tb_fir_accum_resize.sv
// Bench for fir_accum_resize: directed cases with literal expectations plus
// randomized traffic scored against an arithmetic reference model.
module tb_fir_accum_resize;

    localparam int N    = 4;
    localparam int P    = 34;
    localparam int S    = 36;
    localparam int D    = 16;
    localparam int SH_W = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [SH_W-1:0] shift;
    logic [N*P-1:0] acc_din;
    logic           acc_din_valid;
    logic           acc_din_ready;
    logic [D-1:0]   dout;
    logic           dout_valid;
    logic           dout_ready;
    logic           dout_sat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int txn   = 0;
    bit rand_rdy = 1'b0;

    longint exp_dout_q[$];
    bit     exp_sat_q[$];

    fir_accum_resize dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .shift         (shift),
        .acc_din       (acc_din),
        .acc_din_valid (acc_din_valid),
        .acc_din_ready (acc_din_ready),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .dout_sat      (dout_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [N*P-1:0] pack(input longint a, input longint b,
                                            input longint c, input longint d);
        logic [N*P-1:0] v;
        longint l[4];
        longint t;
        l = '{a, b, c, d};
        for (int i = 0; i < N; i++) begin
            t = l[i];
            v[i*P +: P] = t[P-1:0];
        end
        return v;
    endfunction

    // Reference: exact integer sum, floor((sum + half) / 2^sh), clip to D bits.
    task automatic model(input logic [N*P-1:0] din, input logic [SH_W-1:0] sh_in,
                         output longint r, output bit s);
        longint sum = 0;
        int sh;
        logic signed [P-1:0] l;
        sh = int'(sh_in);
        if (sh > S - 1) sh = S - 1;
        for (int i = 0; i < N; i++) begin
            l = din[i*P +: P];
            sum = sum + longint'(l);
        end
        r = (sh == 0) ? sum : ((sum + (64'sd1 <<< (sh - 1))) >>> sh);
        s = 1'b0;
        if (r > 32767) begin r = 32767; s = 1'b1; end
        else if (r < -32768) begin r = -32768; s = 1'b1; end
    endtask

    // Scoreboard/monitor, sampled mid-cycle while inputs are stable.
    bit     rst_prev = 1'b0;
    bit     held = 1'b0;
    logic [D-1:0] held_dout;
    logic   held_sat;
    always @(negedge clk) begin
        longint r;
        bit s;
        longint ed;
        bit es;
        if (rst_prev) begin
            check("reset_outputs_zero",
                  {acc_din_ready, dout_valid, dout_sat, dout}, 0);
        end
        rst_prev = reset || !enable;
        if (reset || !enable) begin
            exp_dout_q.delete();
            exp_sat_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", dout_valid, 1);
                check("hold_dout", dout, held_dout);
                check("hold_sat", dout_sat, held_sat);
            end
            if (acc_din_valid && acc_din_ready) begin
                model(acc_din, shift, r, s);
                exp_dout_q.push_back(r);
                exp_sat_q.push_back(s);
            end
            if (dout_valid && dout_ready) begin
                if (exp_dout_q.size() == 0) begin
                    check("unexpected_dout_valid", 1, 0);
                end else begin
                    ed = exp_dout_q.pop_front();
                    es = exp_sat_q.pop_front();
                    txn++;
                    $display("txn %0d: dout=%0d sat=%0d expected dout=%0d sat=%0d",
                             txn, $signed(dout), dout_sat, ed, es);
                    check("model_dout", longint'($signed(dout)), ed);
                    check("model_sat", dout_sat, es);
                end
            end
            held      = dout_valid && !dout_ready;
            held_dout = dout;
            held_sat  = dout_sat;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) dout_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [N*P-1:0] din, input int sh,
                        output int t_hs, output bit ok);
        int k = 0;
        while (!acc_din_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        ok = acc_din_ready;
        t_hs = 0;
        if (!ok) begin
            fail_now("send_ready");
            return;
        end
        acc_din       = din;
        shift         = SH_W'(sh);
        acc_din_valid = 1'b1;
        @(posedge clk); #1;
        t_hs          = cyc;
        acc_din_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output bit ok);
        int k = 0;
        while (!dout_valid && k < 50) begin
            @(posedge clk); #1; k++;
        end
        ok = dout_valid;
        if (!ok) fail_now(name);
    endtask

    task automatic run_case(input string name, input longint a, input longint b,
                            input longint c, input longint d, input int sh,
                            input longint exp_d, input bit exp_s);
        int t_hs;
        bit ok;
        dout_ready = 1'b1;
        send(pack(a, b, c, d), sh, t_hs, ok);
        if (!ok) return;
        wait_valid({name, "_valid"}, ok);
        if (!ok) return;
        check({name, "_latency"}, cyc + 1 - t_hs, 6);
        check({name, "_dout"}, longint'($signed(dout)), exp_d);
        check({name, "_sat"}, dout_sat, exp_s);
        @(posedge clk); #1;
    endtask

    function automatic longint rand_lane();
        logic [63:0] t;
        case ($urandom_range(0, 2))
            0: return longint'($urandom_range(0, 4000)) - 2000;
            1: return longint'($urandom_range(0, 80000)) - 40000;
            default: begin
                t = {$urandom(), $urandom()};
                return longint'($signed(t[P-1:0]));
            end
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint r;
        bit s;
        int t_hs, k, vcount;
        bit ok;
        logic [D-1:0] bp_dout;

        reset = 1'b1; enable = 1'b1; shift = '0; acc_din = '0;
        acc_din_valid = 1'b0; dout_ready = 1'b1;

        // Pin the reference model with hand-computed values.
        model(pack(100, 200, 300, 400), 0, r, s); check("model_pin_basic", r, 1000);
        model(pack(-3, 0, 0, 0), 1, r, s);         check("model_pin_neg", r, -1);
        model(pack(20000, 20000, 20000, 20000), 0, r, s); check("model_pin_sat", s, 1);
        model(pack(-1, 0, 0, 0), 40, r, s);        check("model_pin_clamp", r, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", acc_din_ready, 0);
        check("reset_valid", dout_valid, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_second_edge", acc_din_ready, 1);

        run_case("basic", 100, 200, 300, 400, 0, 1000, 0);
        run_case("round_pos", 3, 0, 0, 0, 1, 2, 0);
        run_case("round_neg", -3, 0, 0, 0, 1, -1, 0);
        run_case("round_sh2", 5, 0, 0, 0, 2, 1, 0);
        run_case("sat_pos", 20000, 20000, 20000, 20000, 0, 32767, 1);
        run_case("sat_neg", -20000, -20000, -20000, -20000, 0, -32768, 1);
        run_case("nosat_edge", 32767, 32767, 32767, 32767, 2, 32767, 0);
        run_case("shift_clamp", -1, 0, 0, 0, 63, 0, 0);

        // Backpressure: result held, no new input accepted.
        dout_ready = 1'b0;
        send(pack(10, 20, 30, 40), 0, t_hs, ok);
        wait_valid("bp_valid", ok);
        bp_dout = dout;
        check("bp_first_dout", longint'($signed(dout)), 100);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_dout_stable", dout, bp_dout);
            check("bp_ready_low", acc_din_ready, 0);
        end
        acc_din = pack(1, 2, 3, 4); shift = '0; acc_din_valid = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_after_hs_valid", dout_valid, 0);
        check("bp_after_hs_ready", acc_din_ready, 1);
        @(posedge clk); #1;
        acc_din_valid = 1'b0;
        check("bp_second_accepted", acc_din_ready, 0);
        wait_valid("bp2_valid", ok);
        check("bp2_dout", longint'($signed(dout)), 10);
        @(posedge clk); #1;

        // Reset two cycles into the sum.
        send(pack(500, 500, 500, 500), 0, t_hs, ok);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midsum_outs_zero", {acc_din_ready, dout_valid, dout_sat, dout}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("midsum_ready_second_edge", acc_din_ready, 1);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (dout_valid) vcount++;
        end
        check("midsum_no_output", vcount, 0);

        // Enable dropped while a result is waiting.
        dout_ready = 1'b0;
        send(pack(7, 0, 0, 0), 0, t_hs, ok);
        wait_valid("en_valid", ok);
        enable = 1'b0;
        @(posedge clk); #1;
        check("en_drop_valid", dout_valid, 0);
        check("en_drop_ready", acc_din_ready, 0);
        enable = 1'b1;
        run_case("en_new", 1, 1, 1, 1, 0, 4, 0);

        // Randomized traffic with random output backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int sh;
            sh = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 20);
            send(pack(rand_lane(), rand_lane(), rand_lane(), rand_lane()), sh, t_hs, ok);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        dout_ready = 1'b1;
        k = 0;
        while (exp_dout_q.size() != 0 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check("drain_empty", exp_dout_q.size(), 0);
        check("random_txn_seen", (txn >= 200) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_accum_resize.md
# fir_accum_resize

Downstream companion to the configurable FIR core. It takes the N per-stage signed partial accumulators produced at the end of a FIR calculation pass and sums them sequentially into one wide value. It then applies a programmable arithmetic right shift with round-half-up and saturates the result to the data width. The result is presented on a ready/valid output stream, so it becomes the FIR's `dout` path.

## Interface
Parameters:
- G_NUM_STAGES_LOG2, 2, log2 of lane count N.
- G_STAGE_DEPTH_LOG2, 2, log2 of stage depth M (sizes the partial width).
- G_DATA_WIDTH, 16, output width D.
- G_TAP_WIDTH, 16, tap width.
- Derived widths (localparams):
  - P = G_STAGE_DEPTH_LOG2+G_DATA_WIDTH+G_TAP_WIDTH, the partial-accumulator width.
  - S = P+G_NUM_STAGES_LOG2, the sum width.
  - SH_W = $clog2(S).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- enable  in  1  0 behaves as reset.
- shift  in  SH_W  right-shift amount, sampled on input handshake.
- acc_din  in  N*P  signed partials, lane i at [i*P +: P].
- acc_din_valid  in  1  partials valid.
- acc_din_ready  out  1  block can accept.
- dout  out  D  rounded, saturated result.
- dout_valid  out  1  result valid.
- dout_ready  in  1  consumer accepts.
- dout_sat  out  1  saturation occurred for the current dout; qualified by dout_valid.

## Operation
- All outputs are registered. Reset values while reset=1 or enable=0: acc_din_ready=0, dout=0, dout_valid=0, dout_sat=0, state=SM_IDLE.
- SM_IDLE:
  - acc_din_ready<=1.
  - On acc_din_valid & acc_din_ready: capture all N lanes into the lane register array, latch shift (values >S-1 clamp to S-1), sum<=0, lane_cnt<=0, acc_din_ready<=0, go to SM_SUM.
- SM_SUM:
  - Each cycle, sum<=sum+sign_extend(lane[lane_cnt]) at S bits, then lane_cnt++.
  - After lane_cnt==N-1, go to SM_ROUND.
  - Because S=P+log2 N, the sum cannot overflow.
- SM_ROUND:
  - If shift==0, r=sum. Otherwise r=(sum + 2^(shift-1)) >>> shift, computed at S+1 bits.
  - If r>2^(D-1)-1: dout<=2^(D-1)-1, dout_sat<=1.
  - If r<-2^(D-1): dout<=-2^(D-1), dout_sat<=1.
  - Otherwise dout<=r[D-1:0], dout_sat<=0.
  - dout_valid<=1, go to SM_OUT.
- SM_OUT:
  - dout and dout_sat are held stable while dout_valid & !dout_ready.
  - On dout_ready: dout_valid<=0, acc_din_ready<=1, go to SM_IDLE.
- acc_din is ignored in every state other than SM_IDLE. Inputs presented while acc_din_ready=0 are not consumed.
- Reset or enable=0 mid-operation discards the in-flight sum. No output is ever produced from a pre-reset input.

## Timing
- Input handshake at cycle T. SUM occupies T+1..T+N, ROUND occurs at T+N+1, and dout_valid is first high at T+N+2.
- With dout_ready held at 1, the dout handshake completes at T+N+2. acc_din_ready rises at T+N+3, so the minimum initiation interval is N+3 cycles.
- After reset deasserts, acc_din_ready is 1 on the second rising edge.
- dout_valid never drops without a handshake. dout never changes while dout_valid=1.

## Structure
- Shared package fir_pkg: state_t enum (SM_IDLE, SM_SUM, SM_ROUND, SM_OUT) and width helper functions for P, S and SH_W, reusable by the FIR core.
- One combinational sub-module, fir_round_sat (params S, D; ports sum, shift, dout, sat). It isolates the rounding and saturation arithmetic for standalone unit testing.
- Top level holds the FSM, the lane register array, the lane counter and the output registers.

## Test plan
Parameters for all scenarios: N=4, M=4, D=16, P=34.
- Basic sum: lanes 100,200,300,400, shift=0, dout_ready=1 → dout=1000, dout_sat=0, dout_valid first high at T+6.
- Rounding: lanes 3,0,0,0, shift=1 → dout=2. Lanes -3,0,0,0, shift=1 → dout=-1. Lanes 5,0,0,0, shift=2 → dout=1.
- Saturation: four lanes of 20000, shift=0 → dout=32767, dout_sat=1. Four lanes of -20000 → dout=-32768, dout_sat=1. Four lanes of 32767, shift=2 → dout=32767, dout_sat=0.
- Backpressure: hold dout_ready=0 for 10 cycles → dout and dout_sat stable, acc_din_ready=0 throughout. When dout_ready rises, a second input is accepted one cycle after the handshake.
- Reset mid-SUM: assert reset at T+2 → all outputs 0 next cycle. acc_din_ready=1 on the second edge after release, and no dout_valid appears for the aborted input.
- Enable drop: drive enable=0 in SM_OUT → dout_valid=0 next cycle. Re-enable, then the new input lanes 1,1,1,1, shift=0 → dout=4.
